// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, answered LATENCY edges after acceptance.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // the requester holds req_valid (and its fields) until then. rsp_valid is a
  // one-cycle pulse with no back-pressure.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit         LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  lat_wr;
  logic [15:0]           lat_addr;
  logic [15:0]           lat_wdata;
  logic [15:0]           mem [0:(1<<DEPTH_LOG2)-1];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_wr;
  logic [15:0]           acc_addr;
  logic [15:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  misalign;
  logic                  mem_we;
  logic                  unused_addr_bits;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state == S_WAIT) | ((state == S_IDLE) & req_valid);
  assign accept    = req_valid & req_ready;

  // With LATENCY=1 the access happens on the accept edge itself, so it must
  // use the live request fields rather than the (not yet loaded) latches.
  assign enter_resp = ((state == S_WAIT) && (cnt == 4'd0)) || (accept && LAT_ONE);
  assign acc_wr     = (state == S_IDLE) ? req_wr    : lat_wr;
  assign acc_addr   = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign idx        = acc_addr[DEPTH_LOG2:1];

  // Upper address bits (and bit 0 when unchecked) are intentionally ignored.
  assign unused_addr_bits = ^acc_addr;

`ifdef DMEM_MISALIGN_CHK_EN
  logic rsp_err_q;

  assign misalign = acc_addr[0];
  assign rsp_err  = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_q <= misalign;
    end
  end
`else
  assign misalign = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign mem_we = enter_resp & acc_wr & ~misalign & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= 16'd0;
      lat_wdata <= 16'd0;
      rsp_rdata <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (LAT_ONE) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        if (misalign) begin
          rsp_rdata <= 16'd0;
        end else if (acc_wr) begin
          rsp_rdata <= acc_wdata;
        end else begin
          rsp_rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=4/1024-word instance and a LATENCY=1/16-word
// instance, directed cases plus random traffic checked against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_wr    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model store per instance and scoreboard of {known, err, rdata}.
  logic [15:0] mdl   [2][1024];
  bit          known [2][1024];
  logic [17:0] exp_q [$];

  dmem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_wr(req_wr[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_wr(req_wr[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int words_of(input int d);
    return (d == 0) ? 1024 : 16;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: byte address wraps at 2*words bytes, word index drops bit 0.
  task automatic model_access(input int d, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wdata);
    int   idx;
    bit   mis;
    logic [17:0] e;
    idx = (int'(addr) % (2 * words_of(d))) / 2;
    mis = MIS_EN && addr[0];
    if (mis) begin
      e = {1'b1, 1'b1, 16'h0000};
    end else if (wr) begin
      mdl[d][idx]   = wdata;
      known[d][idx] = 1'b1;
      e = {1'b1, 1'b0, wdata};
    end else begin
      e = {known[d][idx], 1'b0, mdl[d][idx]};
    end
    exp_q.push_back(e);
  endtask

  // Driver tasks: called just after a falling edge.
  task automatic drive_req(input int d, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
  endtask

  task automatic wait_accept(input int d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[d]) begin
        check_val("busy_on_req", busy[d], 1);
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    check_val("accepted", ok, 1);
  endtask

  task automatic resp_phase(input int d);
    logic [17:0] e;
    int lat;
    lat = lat_of(d);
    e = exp_q.pop_front();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check_val("rsp_valid", rsp_valid[d], (k == lat));
      check_val("busy_inflight", busy[d], (k < lat));
      check_val("ready_inflight", req_ready[d], 0);
      if (k == lat) begin
        check_val("rsp_err", rsp_err[d], e[16]);
        if (e[17]) check_val("rsp_rdata", rsp_rdata[d], e[15:0]);
      end
    end
  endtask

  task automatic do_txn(input int d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
    int waited;
    drive_req(d, wr, addr, wdata);
    wait_accept(d, waited);
    model_access(d, wr, addr, wdata);
    #1 req_valid[d] = 1'b0;
    resp_phase(d);
  endtask

  // Write, then hold req_valid with a read of the same word throughout.
  task automatic hold_pair(input int d, input logic [15:0] addr, input logic [15:0] wdata);
    int waited;
    drive_req(d, 1'b1, addr, wdata);
    wait_accept(d, waited);
    model_access(d, 1'b1, addr, wdata);
    #1;
    req_wr[d]    = 1'b0;
    req_wdata[d] = 16'h0000;
    resp_phase(d);
    wait_accept(d, waited);
    check_val("hold_gap", waited, 1);
    model_access(d, 1'b0, addr, 16'h0000);
    #1 req_valid[d] = 1'b0;
    resp_phase(d);
  endtask

  task automatic check_idle(input int d);
    check_val("idle_ready", req_ready[d], 1);
    check_val("idle_busy", busy[d], 0);
    check_val("idle_rsp_valid", rsp_valid[d], 0);
  endtask

  initial begin
    int waited;
    logic [15:0] a;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_addr[d]  = 16'h0000;
      req_wdata[d] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_idle(d);
        check_val("reset_rdata", rsp_rdata[d], 16'h0000);
        check_val("reset_err", rsp_err[d], 0);
      end
    end

    // Write then read, LATENCY=4
    do_txn(0, 1'b1, 16'h0010, 16'hBEEF);
    do_txn(0, 1'b0, 16'h0010, 16'h0000);

    hold_pair(0, 16'h0002, 16'h1234);

    // Wrap-around: 0x0804 aliases 0x0004
    do_txn(0, 1'b1, 16'h0804, 16'hA5A5);
    do_txn(0, 1'b0, 16'h0004, 16'h0000);

    // Reset during WAIT drops an in-flight write
    do_txn(0, 1'b1, 16'h0020, 16'h1111);
    drive_req(0, 1'b1, 16'h0020, 16'h2222);
    wait_accept(0, waited);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle(0);
    check_val("midrst_rdata", rsp_rdata[0], 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_val("midrst_no_rsp", rsp_valid[0], 0);
    end
    do_txn(0, 1'b0, 16'h0020, 16'h0000);

    // LATENCY=1 instance, including odd addresses
    do_txn(1, 1'b1, 16'h0002, 16'h5A5A);
    do_txn(1, 1'b0, 16'h0003, 16'h0000);
    do_txn(1, 1'b1, 16'h0003, 16'hFFFF);
    do_txn(1, 1'b0, 16'h0002, 16'h0000);
    hold_pair(1, 16'h0006, 16'h4321);

    // Random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      a = (16'($urandom) & 16'hF800) | 16'($urandom_range(0, 31));
      do_txn(d, 1'($urandom_range(0, 1)), a, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the pipeline's data-memory port. The pipeline's MEM stage issues read/write requests, and this block services them.
- Holds a word-organised 16-bit data store and answers each request after a parameterised multi-cycle latency.
- Raises busy so the hazard logic can stall the pipeline while a request is outstanding.
- Handles exactly one request at a time. There is no queue.

Parameters:
- LATENCY, 4: number of rising clock edges from request acceptance to the edge that raises rsp_valid. Legal range 1..15.
- DEPTH_LOG2, 10: log2 of the number of 16-bit words in the store (default 1024 words).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  16  byte address of the request.
- req_wdata  in  16  write data.
- req_ready  out  1  block can accept a request; high only in IDLE.
- rsp_valid  out  1  one-cycle pulse: access completed.
- rsp_rdata  out  16  read data for reads; echo of the written data for writes.
- rsp_err  out  1  misaligned-access flag, qualified by rsp_valid.
- busy  out  1  stall request to the hazard unit.

Behaviour:
- Reset (async assert, rst_n low):
  - state goes to IDLE, counter 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
  - Store contents are not reset.
- States: IDLE, WAIT, RESP.
- Accept: a request is accepted on an edge where req_valid & req_ready. On that edge the block latches req_wr, req_addr and req_wdata.
  - LATENCY=1: next state is RESP.
  - Otherwise: next state is WAIT with cnt=LATENCY-2.
- WAIT: cnt decrements each edge. When cnt==0, the next state is RESP.
- Store access happens on the edge that enters RESP:
  - write: mem[idx] <= latched wdata.
  - read: rsp_rdata <= mem[idx].
  - write: rsp_rdata <= latched wdata.
- RESP lasts exactly one cycle with rsp_valid=1. The next state is always IDLE.
- Latency: with acceptance at edge E0, rsp_valid is high in the cycle after edge E0+LATENCY-1 and falls at edge E0+LATENCY.
- Index: idx = latched addr[DEPTH_LOG2:1].
  - Bit 0 is ignored unless the optional feature is enabled.
  - Address bits above DEPTH_LOG2 are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
- req_ready = (state==IDLE), purely combinational from state.
- busy = (state==WAIT) | (state==IDLE & req_valid). The second term makes the request cycle stall combinationally.
- Back-to-back requests: the earliest next accept is the IDLE cycle after RESP. Minimum request spacing is LATENCY+1 cycles.
- req_valid asserted while in WAIT or RESP is ignored and not queued. The requester must hold req_valid until accepted.
- rsp_rdata holds its value until the next RESP entry.
- Reset mid-operation (WAIT): the pending request is dropped, an in-flight write is NOT committed, and no rsp_valid is produced.
- Read-after-write to the same address on consecutive transactions returns the newly written value.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined:
  - A request with req_addr[0]=1 is accepted normally and takes the same latency.
  - The store is not written.
  - In RESP: rsp_err=1 and rsp_rdata=0.
  - rsp_err is 0 for aligned requests.
- Undefined: rsp_err is tied 0 and req_addr[0] is ignored.

Test Plan:
- Reset release, idle: req_valid=0 for 10 cycles → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
- Write then read, LATENCY=4:
  - Write addr 0x0010, data 0xBEEF at edge E0 → rsp_valid high only in the cycle after E3, with rsp_rdata=0xBEEF.
  - Read 0x0010 → rsp_rdata=0xBEEF after 4 edges.
- Hold while busy: write 0x0002=0x1234, keep req_valid high with read 0x0002 throughout → read accepted on the first IDLE cycle after RESP, returns 0x1234, and busy stays high until it completes.
- Wrap-around, DEPTH_LOG2=10: write 0x0804=0xA5A5, then read 0x0004 → rsp_rdata=0xA5A5.
- Reset mid-write:
  - Prior contents: 0x0020=0x1111.
  - Write 0x0020=0x2222, assert rst_n=0 during WAIT → no rsp_valid and the write is not committed.
  - After release, read 0x0020 → 0x1111.
- LATENCY=1, with DMEM_MISALIGN_CHK_EN defined:
  - Read 0x0003 → rsp_valid the cycle after accept, rsp_err=1, rsp_rdata=0.
  - Write 0x0003=0xFFFF, then read 0x0002 → the prior value is unchanged.
